switch_egress_reader: RTL and testbench

SWITCH_EGRESS_READER -- requirements
Module: switch_egress_reader

---
 rtl/switch_egress_reader_if.sv | 39 +++
 rtl/switch_egress_reader.sv | 91 +++++++++
 tb/tb_switch_egress_reader.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/switch_egress_reader_if.sv
// Bundle between the switch output VOQ read side, the egress reader and the downstream consumer.
// The master modport is the reader's view; the slave modport is the switch/downstream view.
interface switch_egress_reader_if #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int SEL = $clog2(PORT_NUB);

    logic [PORT_NUB*DATA_WIDTH-1:0] sw_data;
    logic [PORT_NUB*PORT_NUB-1:0]   sw_empty;
    logic [PORT_NUB*SEL-1:0]        sw_rd_sel;
    logic [PORT_NUB-1:0]            sw_rd_en;
    logic [PORT_NUB*DATA_WIDTH-1:0] out_data;
    logic [PORT_NUB*SEL-1:0]        out_src;
    logic [PORT_NUB-1:0]            out_valid;
    logic [PORT_NUB-1:0]            out_ready;

    modport master (
        input  sw_data,
        input  sw_empty,
        input  out_ready,
        output sw_rd_sel,
        output sw_rd_en,
        output out_data,
        output out_src,
        output out_valid
    );

    modport slave (
        output sw_data,
        output sw_empty,
        output out_ready,
        input  sw_rd_sel,
        input  sw_rd_en,
        input  out_data,
        input  out_src,
        input  out_valid
    );
endinterface

// File: rtl/switch_egress_reader.sv
// Per-output-port egress reader: round-robin over the source sub-queues of each switch output,
// fixed one-cycle switch read latency, 2-entry skid FIFO with credit-based read issue.
module switch_egress_reader #(
    parameter int PORT_NUB   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    switch_egress_reader_if.master io_bus
);
    localparam int SEL = $clog2(PORT_NUB);

    for (genvar o = 0; o < PORT_NUB; o++) begin : g_lane
        logic [SEL-1:0]        r_rr_ptr;
        logic                  r_inflight;
        logic [SEL-1:0]        r_inflight_src;
        logic [PORT_NUB-1:0]   r_last_grant;
        logic [DATA_WIDTH-1:0] r_fifo_data [2];
        logic [SEL-1:0]        r_fifo_src  [2];
        logic                  r_rd_ptr;
        logic                  r_wr_ptr;
        logic [1:0]            r_count;

        logic [PORT_NUB-1:0]   w_eligible;
        logic [SEL-1:0]        w_grant;
        logic                  w_any;
        logic                  w_pop;
        logic [1:0]            w_occ;
        logic                  w_credit;
        logic                  w_issue;

        // Empty flags lag a read by one cycle, so last cycle's grant is masked out.
        assign w_eligible = ~io_bus.sw_empty[o*PORT_NUB +: PORT_NUB] & ~r_last_grant;
        assign w_any      = |w_eligible;
        assign w_pop      = (r_count != 2'd0) & io_bus.out_ready[o];
        assign w_occ      = r_count + {1'b0, r_inflight};
        assign w_credit   = (w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop);
        assign w_issue    = rst_n & w_credit & w_any;

        // Reverse scan so the smallest offset from r_rr_ptr wins.
        always_comb begin
            w_grant = r_rr_ptr;
            for (int k = PORT_NUB - 1; k >= 0; k--) begin
                if (w_eligible[r_rr_ptr + SEL'(k)]) begin
                    w_grant = r_rr_ptr + SEL'(k);
                end
            end
        end

        assign io_bus.sw_rd_en[o]                          = w_issue;
        assign io_bus.sw_rd_sel[o*SEL +: SEL]              = w_issue ? w_grant : '0;
        assign io_bus.out_valid[o]                         = (r_count != 2'd0);
        assign io_bus.out_data[o*DATA_WIDTH +: DATA_WIDTH] = r_fifo_data[r_rd_ptr];
        assign io_bus.out_src[o*SEL +: SEL]                = r_fifo_src[r_rd_ptr];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_rr_ptr       <= '0;
                r_inflight     <= 1'b0;
                r_inflight_src <= '0;
                r_last_grant   <= '0;
                r_fifo_data[0] <= '0;
                r_fifo_data[1] <= '0;
                r_fifo_src[0]  <= '0;
                r_fifo_src[1]  <= '0;
                r_rd_ptr       <= 1'b0;
                r_wr_ptr       <= 1'b0;
                r_count        <= 2'd0;
            end else begin
                r_inflight     <= w_issue;
                r_inflight_src <= w_grant;
                if (w_issue) begin
                    r_rr_ptr     <= w_grant + SEL'(1);
                    r_last_grant <= PORT_NUB'(1) << w_grant;
                end else begin
                    r_last_grant <= '0;
                end
                // The switch word for last cycle's strobe is on sw_data now.
                if (r_inflight) begin
                    r_fifo_data[r_wr_ptr] <= io_bus.sw_data[o*DATA_WIDTH +: DATA_WIDTH];
                    r_fifo_src[r_wr_ptr]  <= r_inflight_src;
                    r_wr_ptr              <= ~r_wr_ptr;
                end
                if (w_pop) begin
                    r_rd_ptr <= ~r_rd_ptr;
                end
                r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
            end
        end
    end
endmodule

// File: tb/tb_switch_egress_reader.sv
// Bench for switch_egress_reader: a queue-based switch VOQ model with lagging empty flags plus a
// per-port reference model of credit, round-robin grant and delivery order.
module tb_switch_egress_reader;
    localparam int P  = 4;
    localparam int DW = 32;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    switch_egress_reader_if #(.PORT_NUB(P), .DATA_WIDTH(DW)) bus ();

    switch_egress_reader #(.PORT_NUB(P), .DATA_WIDTH(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]    vq     [P*P][$];
    logic [DW-1:0]    loaded [P*P][$];
    logic [SW+DW-1:0] fifoq  [P][$];
    logic [SW+DW-1:0] dlv    [P][$];
    bit               fl_v     [P];
    logic [SW-1:0]    fl_src   [P];
    logic [DW-1:0]    fl_word  [P];
    int               rr       [P];
    bit               last_v   [P];
    int               last_sel [P];
    bit               pend_en  [P];
    int               pend_sel [P];

    logic [P-1:0]    s_en, s_valid;
    logic [P*SW-1:0] s_sel, s_src;
    logic [P*DW-1:0] s_data;
    int              cyc = 0;

    // Check at the falling edge, advance the model, then act as the switch just after the rising edge.
    task automatic step_cycle();
        @(negedge clk);
        cyc++;
        s_en = bus.sw_rd_en; s_sel = bus.sw_rd_sel; s_valid = bus.out_valid;
        s_data = bus.out_data; s_src = bus.out_src;
        if (!rst_n) begin
            checks++;
            if ({s_en, s_sel, s_valid, s_data, s_src} !== '0) begin
                failures++;
                $display("[TB] FAIL reset_outputs cyc=%0d en=%h sel=%h valid=%h data=%h src=%h, expected all 0",
                         cyc, s_en, s_sel, s_valid, s_data, s_src);
            end
            for (int o = 0; o < P; o++) begin
                fifoq[o].delete(); fl_v[o] = 0; rr[o] = 0; last_v[o] = 0; pend_en[o] = 0;
            end
        end else begin
            for (int o = 0; o < P; o++) begin
                int n, occ, exp_sel, sel;
                bit pop, credit, found, exp_en;
                n = fifoq[o].size();
                checks++;
                if (s_valid[o] !== (n > 0)) begin
                    failures++;
                    $display("[TB] FAIL out_valid port=%0d cyc=%0d got=%b expected=%b", o, cyc, s_valid[o], n > 0);
                end
                if (n > 0 && s_valid[o] === 1'b1) begin
                    checks++;
                    if ({s_src[o*SW +: SW], s_data[o*DW +: DW]} !== fifoq[o][0]) begin
                        failures++;
                        $display("[TB] FAIL out_word port=%0d cyc=%0d got src=%0d data=%h expected src=%0d data=%h",
                                 o, cyc, s_src[o*SW +: SW], s_data[o*DW +: DW],
                                 fifoq[o][0][SW+DW-1:DW], fifoq[o][0][DW-1:0]);
                    end
                end
                pop    = (n > 0) && (bus.out_ready[o] == 1'b1);
                occ    = n + int'(fl_v[o]);
                credit = (occ < 2) || (occ == 2 && pop);
                found  = 0; exp_sel = 0;
                for (int k = 0; k < P; k++) begin
                    int s;
                    s = (rr[o] + k) % P;
                    if (!found && bus.sw_empty[o*P + s] == 1'b0 && !(last_v[o] && last_sel[o] == s)) begin
                        found = 1; exp_sel = s;
                    end
                end
                exp_en = credit && found;
                sel    = int'(s_sel[o*SW +: SW]);
                checks++;
                if (s_en[o] !== exp_en || sel != (exp_en ? exp_sel : 0)) begin
                    failures++;
                    $display("[TB] FAIL read_strobe port=%0d cyc=%0d got en=%b sel=%0d expected en=%b sel=%0d",
                             o, cyc, s_en[o], sel, exp_en, exp_en ? exp_sel : 0);
                end
                if (pop) dlv[o].push_back(fifoq[o].pop_front());
                if (fl_v[o]) fifoq[o].push_back({fl_src[o], fl_word[o]});
                checks++;
                if (fifoq[o].size() + int'(s_en[o] === 1'b1) > 2) begin
                    failures++;
                    $display("[TB] FAIL occupancy port=%0d cyc=%0d got=%0d expected<=2",
                             o, cyc, fifoq[o].size() + int'(s_en[o] === 1'b1));
                end
                fl_v[o]   = (s_en[o] === 1'b1);
                fl_src[o] = SW'(sel);
                if (fl_v[o]) begin
                    rr[o] = (sel + 1) % P; last_v[o] = 1; last_sel[o] = sel;
                end else begin
                    last_v[o] = 0;
                end
                pend_en[o] = fl_v[o]; pend_sel[o] = sel;
            end
        end
        @(posedge clk);
        #1;
        for (int f = 0; f < P*P; f++) bus.sw_empty[f] = (vq[f].size() == 0);
        for (int o = 0; o < P; o++) begin
            if (pend_en[o]) begin
                checks++;
                if (vq[o*P + pend_sel[o]].size() == 0) begin
                    failures++;
                    $display("[TB] FAIL switch_underrun port=%0d sub=%0d cyc=%0d got read of empty queue expected none",
                             o, pend_sel[o], cyc);
                    bus.sw_data[o*DW +: DW] = $urandom;
                end else begin
                    fl_word[o] = vq[o*P + pend_sel[o]].pop_front();
                    bus.sw_data[o*DW +: DW] = fl_word[o];
                end
            end else begin
                bus.sw_data[o*DW +: DW] = $urandom;
            end
        end
    endtask

    task automatic clear_dlv();
        for (int o = 0; o < P; o++) dlv[o].delete();
    endtask

    task automatic test_reset();
        clear_dlv();
        rst_n = 1'b0;
        vq[0].push_back(32'h0000_C0DE);
        repeat (3) step_cycle();
        rst_n = 1'b1;
        step_cycle();
        checks++;
        if (s_en[0] !== 1'b1 || s_sel[1:0] !== 2'd0) begin
            failures++;
            $display("[TB] FAIL first_issue got en=%b sel=%0d expected en=1 sel=0", s_en[0], s_sel[1:0]);
        end
        repeat (3) step_cycle();
        checks++;
        if (dlv[0].size() != 1 || dlv[0][0] !== {2'd0, 32'h0000_C0DE}) begin
            failures++;
            $display("[TB] FAIL reset_release_word got count=%0d expected 1 word C0DE from src 0", dlv[0].size());
        end
    endtask

    task automatic test_single_source();
        int t, got;
        int g[$];
        clear_dlv();
        bus.out_ready = '1;
        vq[2].push_back(32'hA5A5_0001);
        t = -1;
        for (int i = 0; i < 10 && t < 0; i++) begin
            step_cycle();
            if (s_en[0] === 1'b1) t = i;
        end
        checks++;
        if (t < 0 || s_sel[1:0] !== 2'd2) begin
            failures++;
            $display("[TB] FAIL single_grant got issued=%0d sel=%0d expected issued=1 sel=2", t >= 0, s_sel[1:0]);
        end
        step_cycle();
        step_cycle();
        checks++;
        if (s_valid[0] !== 1'b1 || s_data[DW-1:0] !== 32'hA5A5_0001 || s_src[1:0] !== 2'd2) begin
            failures++;
            $display("[TB] FAIL single_latency got valid=%b data=%h src=%0d expected valid=1 data=a5a50001 src=2",
                     s_valid[0], s_data[DW-1:0], s_src[1:0]);
        end
        // Pointer now at 3, so with sub-queues 0 and 3 ready, 3 is granted first.
        vq[0].push_back(32'hA5A5_0002);
        vq[3].push_back(32'hA5A5_0003);
        for (int i = 0; i < 12 && g.size() < 2; i++) begin
            step_cycle();
            if (s_en[0] === 1'b1) g.push_back(int'(s_sel[1:0]));
        end
        got = (g.size() == 2) ? g[0] * 10 + g[1] : -1;
        checks++;
        if (got != 30) begin
            failures++;
            $display("[TB] FAIL rr_after_single got order code=%0d expected=30", got);
        end
        repeat (4) step_cycle();
    endtask

    task automatic test_round_robin();
        int g[$];
        int gc[$];
        logic [SW+DW-1:0] exp_word;
        clear_dlv();
        bus.out_ready = '1;
        for (int k = 0; k < 3; k++)
            for (int s = 0; s < P; s++) vq[P + s].push_back(32'h1000_0000 | (s << 8) | k);
        for (int i = 0; i < 40 && dlv[1].size() < 12; i++) begin
            step_cycle();
            if (s_en[1] === 1'b1) begin
                g.push_back(int'(s_sel[3:2])); gc.push_back(cyc);
            end
        end
        checks++;
        if (g.size() != 12 || gc[gc.size()-1] - gc[0] != 11) begin
            failures++;
            $display("[TB] FAIL rr_throughput got grants=%0d expected 12 grants in 12 consecutive cycles", g.size());
        end
        for (int i = 0; i < g.size(); i++) begin
            checks++;
            if (g[i] != i % P) begin
                failures++;
                $display("[TB] FAIL rr_order idx=%0d got=%0d expected=%0d", i, g[i], i % P);
            end
        end
        checks++;
        if (dlv[1].size() != 12) begin
            failures++;
            $display("[TB] FAIL rr_delivered got=%0d expected=12", dlv[1].size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                exp_word = {SW'(i % P), 32'h1000_0000 | ((i % P) << 8) | (i / P)};
                checks++;
                if (dlv[1][i] !== exp_word) begin
                    failures++;
                    $display("[TB] FAIL rr_word idx=%0d got=%h expected=%h", i, dlv[1][i], exp_word);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] w [4];
        int issues;
        bit seen;
        clear_dlv();
        bus.out_ready = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            w[k] = $urandom; vq[2*P + 1].push_back(w[k]);
        end
        issues = 0; seen = 0;
        for (int i = 0; i < 14; i++) begin
            step_cycle();
            if (s_en[2] === 1'b1) issues++;
            if (seen) begin
                checks++;
                if (s_valid[2] !== 1'b1 || s_data[2*DW +: DW] !== w[0] || s_src[2*SW +: SW] !== 2'd1) begin
                    failures++;
                    $display("[TB] FAIL held_word cyc=%0d got valid=%b data=%h src=%0d expected valid=1 data=%h src=1",
                             cyc, s_valid[2], s_data[2*DW +: DW], s_src[2*SW +: SW], w[0]);
                end
            end else if (s_valid[2] === 1'b1) begin
                seen = 1;
            end
        end
        checks++;
        if (issues != 2 || !seen) begin
            failures++;
            $display("[TB] FAIL stall_reads got issues=%0d valid_seen=%0d expected issues=2 valid_seen=1", issues, seen);
        end
        bus.out_ready = '1;
        for (int i = 0; i < 20 && dlv[2].size() < 4; i++) step_cycle();
        checks++;
        if (dlv[2].size() != 4) begin
            failures++;
            $display("[TB] FAIL stall_drain got=%0d expected=4", dlv[2].size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (dlv[2][k] !== {2'd1, w[k]}) begin
                    failures++;
                    $display("[TB] FAIL stall_order idx=%0d got=%h expected=%h", k, dlv[2][k], {2'd1, w[k]});
                end
            end
        end
    endtask

    task automatic test_credit();
        bit mixed_seen;
        int n_src0, n_src2;
        clear_dlv();
        mixed_seen = 0;
        for (int k = 0; k < 3; k++) begin
            vq[3*P + 0].push_back(32'h3000_0000 | k);
            vq[3*P + 2].push_back(32'h3200_0000 | k);
        end
        for (int i = 0; i < 40 && dlv[3].size() < 6; i++) begin
            bus.out_ready[3] = (i % 3 != 1);
            step_cycle();
            if (fifoq[3].size() == 1 && fl_v[3]) mixed_seen = 1;
        end
        bus.out_ready = '1;
        checks++;
        if (dlv[3].size() != 6 || !mixed_seen) begin
            failures++;
            $display("[TB] FAIL credit_drain got words=%0d fifo_plus_flight_seen=%0d expected words=6 seen=1",
                     dlv[3].size(), mixed_seen);
        end
        n_src0 = 0; n_src2 = 0;
        for (int i = 0; i < dlv[3].size(); i++) begin
            checks++;
            if (dlv[3][i][SW+DW-1:DW] == 2'd0) begin
                if (dlv[3][i][DW-1:0] !== (32'h3000_0000 | n_src0)) begin
                    failures++;
                    $display("[TB] FAIL credit_order idx=%0d got=%h expected=%h", i, dlv[3][i][DW-1:0], 32'h3000_0000 | n_src0);
                end
                n_src0++;
            end else begin
                if (dlv[3][i] !== {2'd2, 32'h3200_0000 | n_src2}) begin
                    failures++;
                    $display("[TB] FAIL credit_order idx=%0d got=%h expected=%h", i, dlv[3][i], {2'd2, 32'h3200_0000 | n_src2});
                end
                n_src2++;
            end
        end
    endtask

    task automatic test_reset_inflight();
        int t, first;
        logic [DW-1:0] w1, w3;
        clear_dlv();
        bus.out_ready = '1;
        vq[1].push_back(32'hDEAD_0001);
        t = -1;
        for (int i = 0; i < 10 && t < 0; i++) begin
            step_cycle();
            if (s_en[0] === 1'b1) t = i;
        end
        rst_n = 1'b0;
        step_cycle();
        rst_n = 1'b1;
        w1 = $urandom; w3 = $urandom;
        vq[1].push_back(w1);
        vq[3].push_back(w3);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            step_cycle();
            if (first < 0 && s_en[0] === 1'b1) first = int'(s_sel[1:0]);
        end
        checks++;
        if (t < 0 || first != 1) begin
            failures++;
            $display("[TB] FAIL restart_grant got pre_issue=%0d first=%0d expected pre_issue=1 first=1", t >= 0, first);
        end
        checks++;
        if (dlv[0].size() != 2 || dlv[0][0] !== {2'd1, w1} || dlv[0][1] !== {2'd3, w3}) begin
            failures++;
            $display("[TB] FAIL reset_discard got words=%0d expected 2 words (src1 then src3) and no DEAD0001",
                     dlv[0].size());
        end
    endtask

    task automatic test_all_empty();
        bus.out_ready = '1;
        repeat (6) step_cycle();
        bus.out_ready = 4'($urandom);
        for (int i = 0; i < 8; i++) begin
            step_cycle();
            checks++;
            if (s_en !== '0 || s_valid !== '0 || bus.sw_empty !== '1) begin
                failures++;
                $display("[TB] FAIL all_empty cyc=%0d got en=%b valid=%b empty=%h expected en=0 valid=0 empty=ffff",
                         cyc, s_en, s_valid, bus.sw_empty);
            end
        end
    endtask

    task automatic test_random();
        bit idle;
        int n_loaded, n_dlv, s;
        logic [DW-1:0] w;
        clear_dlv();
        n_loaded = 0;
        for (int f = 0; f < P*P; f++) loaded[f].delete();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) begin
                int f;
                f = $urandom_range(P*P - 1, 0);
                w = $urandom;
                vq[f].push_back(w); loaded[f].push_back(w); n_loaded++;
            end
            bus.out_ready = 4'($urandom);
            step_cycle();
        end
        bus.out_ready = '1;
        idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            step_cycle();
            idle = 1;
            for (int f = 0; f < P*P; f++) if (vq[f].size() != 0) idle = 0;
            for (int o = 0; o < P; o++) if (fifoq[o].size() != 0 || fl_v[o]) idle = 0;
        end
        n_dlv = 0;
        for (int o = 0; o < P; o++) n_dlv += dlv[o].size();
        checks++;
        if (!idle || n_dlv != n_loaded) begin
            failures++;
            $display("[TB] FAIL random_drain got idle=%0d delivered=%0d expected idle=1 delivered=%0d", idle, n_dlv, n_loaded);
        end
        for (int o = 0; o < P; o++) begin
            for (int i = 0; i < dlv[o].size(); i++) begin
                s = int'(dlv[o][i][SW+DW-1:DW]);
                checks++;
                if (loaded[o*P + s].size() == 0 || dlv[o][i][DW-1:0] !== loaded[o*P + s][0]) begin
                    failures++;
                    $display("[TB] FAIL random_order port=%0d src=%0d idx=%0d got=%h", o, s, i, dlv[o][i][DW-1:0]);
                end
                if (loaded[o*P + s].size() != 0) void'(loaded[o*P + s].pop_front());
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.sw_data   = '0;
        bus.sw_empty  = '1;
        bus.out_ready = '1;
        for (int o = 0; o < P; o++) begin
            fl_v[o] = 0; fl_src[o] = '0; fl_word[o] = '0; rr[o] = 0;
            last_v[o] = 0; last_sel[o] = 0; pend_en[o] = 0; pend_sel[o] = 0;
        end
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_credit();
        test_reset_inflight();
        test_all_empty();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog got no finish expected finish before 2ms");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
